// File: rtl/viterbi_ber_checker.sv
// rtl/viterbi_ber_checker.sv - BER monitor: latency search, lock tracking, saturating bit/error counters
// Compares decoded bits against a delayed copy of the encoder input stream.
module viterbi_ber_checker #(
   parameter int MAX_LAT  = 64,
   parameter int LOCK_WIN = 32,
   parameter int LOCK_ERR = 2,
   parameter int LOSS_ERR = 8,
   parameter int CT_W     = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ref_valid_i,
   input  logic                       ref_bit_i,
   input  logic                       dec_valid_i,
   input  logic                       dec_bit_i,
   input  logic                       clear_i,
   output logic                       locked_o,
   output logic [$clog2(MAX_LAT)-1:0] latency_o,
   output logic [CT_W-1:0]            bit_ct_o,
   output logic [CT_W-1:0]            err_ct_o,
   output logic                       err_o
);

   localparam int LAT_W = $clog2(MAX_LAT);
   localparam int WIN_W = $clog2(LOCK_WIN + 1);

   localparam logic [0:0] ST_SEARCH = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]         state;
   logic [MAX_LAT-1:0] hist;
   logic [LAT_W-1:0]   wr_ptr;
   logic [LAT_W-1:0]   fill;
   logic [LAT_W-1:0]   rd_idx;
   logic [LAT_W-1:0]   lat_nx;
   logic [WIN_W-1:0]   win_ct;
   logic [WIN_W-1:0]   win_err;
   logic [WIN_W-1:0]   win_ct_nx;
   logic [WIN_W-1:0]   win_err_nx;
   logic               cmp_en;
   logic               mismatch;
   logic               win_done;
   logic               lock_ok;
   logic               lock_lost;

   // Read side uses the pre-write pointer, so a same-cycle ref write is never seen.
   always_comb begin
      cmp_en     = dec_valid_i && (fill >= latency_o);
      rd_idx     = wr_ptr - latency_o;
      mismatch   = cmp_en && (dec_bit_i != hist[rd_idx]);
      win_ct_nx  = win_ct + WIN_W'(1);
      win_err_nx = win_err + WIN_W'(mismatch);
      win_done   = (win_ct_nx == WIN_W'(LOCK_WIN));
      lock_ok    = (win_err_nx <= WIN_W'(LOCK_ERR));
      lock_lost  = (win_err_nx == WIN_W'(LOSS_ERR + 1));
      lat_nx     = (latency_o == LAT_W'(MAX_LAT - 1)) ? LAT_W'(1) : latency_o + LAT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (ref_valid_i) begin
         hist[wr_ptr] <= ref_bit_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_SEARCH;
         locked_o  <= 1'b0;
         latency_o <= LAT_W'(1);
         wr_ptr    <= '0;
         fill      <= '0;
         win_ct    <= '0;
         win_err   <= '0;
         bit_ct_o  <= '0;
         err_ct_o  <= '0;
         err_o     <= 1'b0;
      end else begin
         err_o <= (state == ST_LOCKED) && mismatch;

         if (ref_valid_i) begin
            wr_ptr <= wr_ptr + LAT_W'(1);
            if (fill != LAT_W'(MAX_LAT - 1)) begin
               fill <= fill + LAT_W'(1);
            end
         end

         // Clear beats a coincident compare; err_o above is independent of it.
         if (clear_i) begin
            bit_ct_o <= '0;
            err_ct_o <= '0;
         end else if (cmp_en && (state == ST_LOCKED)) begin
            if (bit_ct_o != '1) begin
               bit_ct_o <= bit_ct_o + CT_W'(1);
            end
            if (mismatch && (err_ct_o != '1)) begin
               err_ct_o <= err_ct_o + CT_W'(1);
            end
         end

         if (cmp_en) begin
            if (state == ST_SEARCH) begin
               if (win_done) begin
                  win_ct  <= '0;
                  win_err <= '0;
                  if (lock_ok) begin
                     state    <= ST_LOCKED;
                     locked_o <= 1'b1;
                  end else begin
                     latency_o <= lat_nx;
                  end
               end else begin
                  win_ct  <= win_ct_nx;
                  win_err <= win_err_nx;
               end
            end else begin
               // Error burst drops lock immediately, even mid-window.
               if (lock_lost) begin
                  state     <= ST_SEARCH;
                  locked_o  <= 1'b0;
                  latency_o <= LAT_W'(1);
                  win_ct    <= '0;
                  win_err   <= '0;
               end else if (win_done) begin
                  win_ct  <= '0;
                  win_err <= '0;
               end else begin
                  win_ct  <= win_ct_nx;
                  win_err <= win_err_nx;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb/tb_viterbi_ber_checker.sv - directed bench for viterbi_ber_checker
// Reference stream is a xorshift PRBS; the decoded stream is that stream delayed 5 strobes.
module tb_viterbi_ber_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ref_valid = 1'b0;
   logic       ref_bit = 1'b0;
   logic       dec_valid = 1'b0;
   logic       dec_bit = 1'b0;
   logic       clear = 1'b0;
   logic       clear2 = 1'b0;

   logic       locked;
   logic [5:0] latency;
   logic [31:0] bit_ct;
   logic [31:0] err_ct;
   logic       err;

   logic       locked2;
   logic [5:0] latency2;
   logic [3:0] bit_ct2;
   logic [3:0] err_ct2;
   logic       err2;

   int checks = 0;
   int errors = 0;
   int n = 0;
   int cmp = 0;
   int base = 0;
   int err_seen = 0;
   logic [31:0] prng = 32'h1234_5678;
   logic ref_mem [0:2047];

   always #5 clk = ~clk;

   viterbi_ber_checker #(.MAX_LAT(64), .LOCK_WIN(32), .LOCK_ERR(2), .LOSS_ERR(8), .CT_W(32)) dut (
      .clk(clk), .rst(rst),
      .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
      .dec_valid_i(dec_valid), .dec_bit_i(dec_bit),
      .clear_i(clear),
      .locked_o(locked), .latency_o(latency),
      .bit_ct_o(bit_ct), .err_ct_o(err_ct), .err_o(err)
   );

   viterbi_ber_checker #(.MAX_LAT(64), .LOCK_WIN(32), .LOCK_ERR(2), .LOSS_ERR(8), .CT_W(4)) dut2 (
      .clk(clk), .rst(rst),
      .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
      .dec_valid_i(dec_valid), .dec_bit_i(dec_bit),
      .clear_i(clear2),
      .locked_o(locked2), .latency_o(latency2),
      .bit_ct_o(bit_ct2), .err_ct_o(err_ct2), .err_o(err2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic rb, input logic dv, input logic db, input logic clr);
      ref_valid = rv;
      ref_bit   = rb;
      dec_valid = dv;
      dec_bit   = db;
      clear     = clr;
      @(posedge clk);
      #1;
      ref_valid = 1'b0;
      dec_valid = 1'b0;
      clear     = 1'b0;
   endtask

   // One ref strobe; dec carries the ref bit from 5 strobes earlier, optionally inverted.
   task automatic strobe(input logic bad, input logic clr);
      logic b;
      logic d;
      prng = prng ^ (prng << 13);
      prng = prng ^ (prng >> 17);
      prng = prng ^ (prng << 5);
      b = prng[0];
      ref_mem[n] = b;
      d = 1'b0;
      if (n >= 5) begin
         d = ref_mem[n-5] ^ bad;
         cmp++;
      end
      drive(1'b1, b, (n >= 5), d, clr);
      n++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_latency", 32'(latency), 32'd1);
      chk("rst_bit_ct", bit_ct, 32'd0);
      chk("rst_err_ct", err_ct, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b1;

      // dec strobes with an empty history must not advance the window
      repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("early_dec_latency", 32'(latency), 32'd1);
      chk("early_dec_locked", 32'(locked), 32'd0);

      // Lock acquisition: candidates 1..4 fail, 5 locks on compare 160
      while (cmp < 32) strobe(1'b0, 1'b0);
      chk("search_lat2", 32'(latency), 32'd2);
      chk("search_unlocked", 32'(locked), 32'd0);
      while (cmp < 159) strobe(1'b0, 1'b0);
      chk("prelock_locked", 32'(locked), 32'd0);
      chk("prelock_latency", 32'(latency), 32'd5);
      strobe(1'b0, 1'b0);
      chk("lock_locked", 32'(locked), 32'd1);
      chk("lock_latency", 32'(latency), 32'd5);
      chk("lock_bit_ct", bit_ct, 32'd0);
      chk("lock_err_ct", err_ct, 32'd0);
      chk("lock_err", 32'(err), 32'd0);
      chk("lock2_locked", 32'(locked2), 32'd1);
      chk("lock2_latency", 32'(latency2), 32'd5);

      // Counting: bits 10, 40, 41 inverted
      for (int k = 1; k <= 100; k++) begin
         logic bad;
         bad = (k == 10) || (k == 40) || (k == 41);
         strobe(bad, 1'b0);
         chk($sformatf("count_err_o_%0d", k), 32'(err), 32'(bad));
         if (k == 10) chk("count_err2_o", 32'(err2), 32'd1);
         if (k == 20) chk("sat_bit_ct2", 32'(bit_ct2), 32'd15);
      end
      chk("count_bit_ct", bit_ct, 32'd100);
      chk("count_err_ct", err_ct, 32'd3);
      chk("count_locked", 32'(locked), 32'd1);
      chk("count_latency", 32'(latency), 32'd5);
      chk("sat_hold_bit_ct2", 32'(bit_ct2), 32'd15);
      chk("count_err_ct2", 32'(err_ct2), 32'd3);

      // Clear coincident with a mismatch
      strobe(1'b1, 1'b1);
      chk("clear_err_o", 32'(err), 32'd1);
      chk("clear_bit_ct", bit_ct, 32'd0);
      chk("clear_err_ct", err_ct, 32'd0);
      chk("clear_locked", 32'(locked), 32'd1);
      strobe(1'b0, 1'b0);
      chk("postclear_bit_ct", bit_ct, 32'd1);
      chk("postclear_err_ct", err_ct, 32'd0);

      // Finish the current window (6 compares in), then a 9-error burst
      repeat (26) strobe(1'b0, 1'b0);
      repeat (8) strobe(1'b1, 1'b0);
      chk("burst8_locked", 32'(locked), 32'd1);
      chk("burst8_err_ct", err_ct, 32'd8);
      strobe(1'b1, 1'b0);
      chk("loss_locked", 32'(locked), 32'd0);
      chk("loss_latency", 32'(latency), 32'd1);
      chk("loss_err_ct", err_ct, 32'd9);
      chk("loss_bit_ct", bit_ct, 32'd36);
      chk("loss_err_o", 32'(err), 32'd1);

      // Relock on a clean stream; nothing is counted and err_o stays low while searching
      base = cmp;
      err_seen = 0;
      while (cmp < base + 159) begin
         strobe(1'b0, 1'b0);
         if (err) err_seen++;
      end
      chk("research_err_o", 32'(err_seen), 32'd0);
      chk("research_bit_ct", bit_ct, 32'd36);
      chk("research_locked", 32'(locked), 32'd0);
      strobe(1'b0, 1'b0);
      chk("relock_locked", 32'(locked), 32'd1);
      chk("relock_latency", 32'(latency), 32'd5);
      chk("relock_err_ct", err_ct, 32'd9);

      // Asynchronous reset mid-LOCKED while err_o is high
      strobe(1'b1, 1'b0);
      chk("prereset_err_o", 32'(err), 32'd1);
      rst = 1'b0;
      #2;
      chk("async_locked", 32'(locked), 32'd0);
      chk("async_latency", 32'(latency), 32'd1);
      chk("async_bit_ct", bit_ct, 32'd0);
      chk("async_err_ct", err_ct, 32'd0);
      chk("async_err", 32'(err), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // lat=1 with simultaneous strobes: compare must see the previous ref bit
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, ((i + 1) % 2) == 1, 1'b1, (i % 2) == 1, 1'b0);
         if (i == 30) chk("lat1_prelock", 32'(locked), 32'd0);
      end
      chk("lat1_locked", 32'(locked), 32'd1);
      chk("lat1_latency", 32'(latency), 32'd1);
      chk("lat1_bit_ct", bit_ct, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
